urv_dm_arbiter: RTL and testbench

URV_DM_ARBITER -- requirements
Module: urv_dm_arbiter

---
 rtl/urv_dm_arbiter_if.sv | 48 ++++
 rtl/urv_dm_arbiter.sv | 120 ++++++++++++
 tb/tb_urv_dm_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/urv_dm_arbiter_if.sv
// Bus bundle for urv_dm_arbiter: core port, aux (debug/DMA) port and shared memory port.
// slave is the arbiter's view; master is the view of the surrounding requesters and memory.
interface urv_dm_arbiter_if;
  logic [31:0] c_addr_i;
  logic [31:0] c_data_i;
  logic [3:0]  c_select_i;
  logic        c_load_i;
  logic        c_store_i;
  logic        c_stall_req_o;
  logic [31:0] c_load_data_o;
  logic        c_load_valid_o;

  logic [31:0] a_addr_i;
  logic [31:0] a_data_i;
  logic [3:0]  a_select_i;
  logic        a_load_i;
  logic        a_store_i;
  logic        a_ack_o;
  logic [31:0] a_load_data_o;
  logic        a_load_valid_o;

  logic [31:0] m_addr_o;
  logic [31:0] m_data_o;
  logic [3:0]  m_select_o;
  logic        m_load_o;
  logic        m_store_o;
  logic        m_ready_i;
  logic [31:0] m_load_data_i;
  logic        m_load_valid_i;

  modport slave (
    input  c_addr_i, c_data_i, c_select_i, c_load_i, c_store_i,
    output c_stall_req_o, c_load_data_o, c_load_valid_o,
    input  a_addr_i, a_data_i, a_select_i, a_load_i, a_store_i,
    output a_ack_o, a_load_data_o, a_load_valid_o,
    output m_addr_o, m_data_o, m_select_o, m_load_o, m_store_o,
    input  m_ready_i, m_load_data_i, m_load_valid_i
  );

  modport master (
    output c_addr_i, c_data_i, c_select_i, c_load_i, c_store_i,
    input  c_stall_req_o, c_load_data_o, c_load_valid_o,
    output a_addr_i, a_data_i, a_select_i, a_load_i, a_store_i,
    input  a_ack_o, a_load_data_o, a_load_valid_o,
    input  m_addr_o, m_data_o, m_select_o, m_load_o, m_store_o,
    output m_ready_i, m_load_data_i, m_load_valid_i
  );
endinterface

// File: rtl/urv_dm_arbiter.sv
// Two-port (core, aux) arbiter onto a single memory port with at most one load outstanding.
// Define URV_DM_ARB_FAIR_EN to let aux win after g_starve_limit consecutive contended core grants.
module urv_dm_arbiter #(
  parameter int unsigned g_starve_limit = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  urv_dm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWaitC, StWaitA} state_e;

  state_e      state_q;
  logic [31:0] c_load_data_q, a_load_data_q;
  logic        c_load_valid_q, a_load_valid_q;

  logic        c_req, a_req;
  logic        aux_favoured;
  logic        grant_c, grant_a;
  logic        issue_load, issue_store;
  logic        accept;
  logic [31:0] sel_addr, sel_data;
  logic [3:0]  sel_select;

  always_comb begin
    c_req       = bus.c_load_i | bus.c_store_i;
    a_req       = bus.a_load_i | bus.a_store_i;
    grant_c     = 1'b0;
    grant_a     = 1'b0;
    if (!rst_i && state_q == StIdle) begin
      grant_c = c_req & ~(a_req & aux_favoured);
      grant_a = a_req & ~grant_c;
    end

    // Load wins over store when a requester asserts both.
    issue_load  = (grant_c & bus.c_load_i) | (grant_a & bus.a_load_i);
    issue_store = (grant_c & bus.c_store_i & ~bus.c_load_i) |
                  (grant_a & bus.a_store_i & ~bus.a_load_i);
    accept      = (issue_load | issue_store) & bus.m_ready_i;

    if (grant_a) begin
      sel_addr   = bus.a_addr_i;
      sel_data   = bus.a_data_i;
      sel_select = bus.a_select_i;
    end else begin
      sel_addr   = bus.c_addr_i;
      sel_data   = bus.c_data_i;
      sel_select = bus.c_select_i;
    end
  end

  assign bus.m_addr_o       = sel_addr;
  assign bus.m_data_o       = sel_data;
  assign bus.m_select_o     = sel_select;
  assign bus.m_load_o       = issue_load;
  assign bus.m_store_o      = issue_store;
  assign bus.a_ack_o        = grant_a & accept;
  assign bus.c_stall_req_o  = ~rst_i & c_req & ~(grant_c & accept);
  assign bus.c_load_data_o  = c_load_data_q;
  assign bus.c_load_valid_o = c_load_valid_q;
  assign bus.a_load_data_o  = a_load_data_q;
  assign bus.a_load_valid_o = a_load_valid_q;

`ifdef URV_DM_ARB_FAIR_EN
  logic [2:0] starve_q;

  assign aux_favoured = (starve_q == 3'(g_starve_limit));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= 3'd0;
    end else if (!a_req || (grant_a && accept)) begin
      starve_q <= 3'd0;
    end else if (grant_c && accept && starve_q != 3'd7) begin
      starve_q <= starve_q + 3'd1;
    end
  end
`else
  logic unused_starve_limit;

  assign aux_favoured        = 1'b0;
  assign unused_starve_limit = ^g_starve_limit;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      c_load_data_q  <= 32'h0;
      a_load_data_q  <= 32'h0;
      c_load_valid_q <= 1'b0;
      a_load_valid_q <= 1'b0;
    end else begin
      c_load_valid_q <= 1'b0;
      a_load_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept && issue_load) begin
            state_q <= grant_a ? StWaitA : StWaitC;
          end
        end
        StWaitC: begin
          if (bus.m_load_valid_i) begin
            c_load_data_q  <= bus.m_load_data_i;
            c_load_valid_q <= 1'b1;
            state_q        <= StIdle;
          end
        end
        StWaitA: begin
          if (bus.m_load_valid_i) begin
            a_load_data_q  <= bus.m_load_data_i;
            a_load_valid_q <= 1'b1;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Self-checking bench for urv_dm_arbiter: IDLE vector table, directed multi-cycle sequences
// and a randomized run against a transaction-level model.
module tb_urv_dm_arbiter;
  localparam int unsigned Limit = 4;
`ifdef URV_DM_ARB_FAIR_EN
  localparam bit Fair = 1'b1;
`else
  localparam bit Fair = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  urv_dm_arbiter_if bus();

  urv_dm_arbiter #(.g_starve_limit(Limit)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear();
    bus.c_addr_i = 32'h100;  bus.c_data_i = 32'h1111_1111; bus.c_select_i = 4'h3;
    bus.c_load_i = 1'b0;     bus.c_store_i = 1'b0;
    bus.a_addr_i = 32'h200;  bus.a_data_i = 32'h2222_2222; bus.a_select_i = 4'hc;
    bus.a_load_i = 1'b0;     bus.a_store_i = 1'b0;
    bus.m_ready_i = 1'b0;    bus.m_load_data_i = 32'h0;    bus.m_load_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear();
    tick();
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic cl, cs, al, as, rdy;
    logic el, es;
    int   gnt;  // 0 none, 1 core, 2 aux
    logic estall, eack;
  } vec_t;

  vec_t vecs[10];

  // Random-phase requester and model state.
  bit          c_busy, a_busy, c_ld, c_st, a_ld, a_st;
  logic [31:0] c_ad, a_ad;
  int          outst;  // 0 none, 1 core load, 2 aux load
  bit          exp_cv, exp_av;
  logic [31:0] exp_cd, exp_ad;
  int          starve;

  initial begin
    vecs[0] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 0, 1, 0, 1, 1, 0, 0};
    vecs[2] = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 0};
    vecs[3] = '{1, 0, 0, 0, 1, 1, 0, 1, 0, 0};
    vecs[4] = '{1, 1, 0, 0, 1, 1, 0, 1, 0, 0};
    vecs[5] = '{0, 0, 0, 1, 1, 0, 1, 2, 0, 1};
    vecs[6] = '{0, 0, 1, 0, 0, 1, 0, 2, 0, 0};
    vecs[7] = '{0, 1, 0, 1, 1, 0, 1, 1, 0, 0};
    vecs[8] = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 0};
    vecs[9] = '{0, 0, 1, 1, 1, 1, 0, 2, 0, 1};

    rst_i = 1'b1;
    clear();

    // Outputs gated while reset is held, even with requests present.
    bus.c_load_i = 1'b1; bus.a_store_i = 1'b1; bus.m_ready_i = 1'b1;
    tick(); settle();
    chk("rst_m_load", bus.m_load_o, 1'b0);
    chk("rst_m_store", bus.m_store_o, 1'b0);
    chk("rst_a_ack", bus.a_ack_o, 1'b0);
    chk("rst_c_stall", bus.c_stall_req_o, 1'b0);
    chk("rst_c_valid", bus.c_load_valid_o, 1'b0);
    chk("rst_a_valid", bus.a_load_valid_o, 1'b0);
    chk("rst_c_data", bus.c_load_data_o, 32'h0);
    chk("rst_a_data", bus.a_load_data_o, 32'h0);
    tick();

    for (int i = 0; i < 10; i++) begin
      do_reset();
      bus.c_load_i = vecs[i].cl; bus.c_store_i = vecs[i].cs;
      bus.a_load_i = vecs[i].al; bus.a_store_i = vecs[i].as;
      bus.m_ready_i = vecs[i].rdy;
      settle();
      chk($sformatf("vec%0d_m_load", i), bus.m_load_o, vecs[i].el);
      chk($sformatf("vec%0d_m_store", i), bus.m_store_o, vecs[i].es);
      chk($sformatf("vec%0d_c_stall", i), bus.c_stall_req_o, vecs[i].estall);
      chk($sformatf("vec%0d_a_ack", i), bus.a_ack_o, vecs[i].eack);
      if (vecs[i].gnt == 1) begin
        chk($sformatf("vec%0d_addr", i), bus.m_addr_o, 32'h100);
        chk($sformatf("vec%0d_data", i), bus.m_data_o, 32'h1111_1111);
        chk($sformatf("vec%0d_sel", i), {28'h0, bus.m_select_o}, 32'h3);
      end else if (vecs[i].gnt == 2) begin
        chk($sformatf("vec%0d_addr", i), bus.m_addr_o, 32'h200);
        chk($sformatf("vec%0d_data", i), bus.m_data_o, 32'h2222_2222);
        chk($sformatf("vec%0d_sel", i), {28'h0, bus.m_select_o}, 32'hc);
      end
      tick();
    end

    // Core load round trip.
    do_reset();
    bus.c_load_i = 1'b1; bus.m_ready_i = 1'b1;
    settle();
    chk("ld_issue", bus.m_load_o, 1'b1);
    chk("ld_stall", bus.c_stall_req_o, 1'b0);
    tick();
    bus.c_load_i = 1'b0;
    settle();
    chk("ld_wait_noissue", bus.m_load_o, 1'b0);
    tick();
    bus.m_load_valid_i = 1'b1; bus.m_load_data_i = 32'hcafe_f00d;
    settle();
    chk("ld_ret_novalid", bus.c_load_valid_o, 1'b0);
    tick();
    bus.m_load_valid_i = 1'b0;
    settle();
    chk("ld_c_valid", bus.c_load_valid_o, 1'b1);
    chk("ld_c_data", bus.c_load_data_o, 32'hcafe_f00d);
    chk("ld_a_valid", bus.a_load_valid_o, 1'b0);
    tick(); settle();
    chk("ld_pulse_end", bus.c_load_valid_o, 1'b0);
    chk("ld_data_hold", bus.c_load_data_o, 32'hcafe_f00d);
    tick();

    // Spurious return in IDLE is ignored.
    bus.m_load_valid_i = 1'b1; bus.m_load_data_i = 32'h1234_5678;
    tick();
    bus.m_load_valid_i = 1'b0;
    settle();
    chk("idle_ret_c_valid", bus.c_load_valid_o, 1'b0);
    chk("idle_ret_a_valid", bus.a_load_valid_o, 1'b0);
    chk("idle_ret_c_data", bus.c_load_data_o, 32'hcafe_f00d);
    tick();

    // Simultaneous stores: core first, aux next cycle.
    do_reset();
    bus.c_store_i = 1'b1; bus.a_store_i = 1'b1; bus.m_ready_i = 1'b1;
    settle();
    chk("ss_core_addr", bus.m_addr_o, 32'h100);
    chk("ss_a_ack0", bus.a_ack_o, 1'b0);
    chk("ss_stall0", bus.c_stall_req_o, 1'b0);
    tick();
    bus.c_store_i = 1'b0;
    settle();
    chk("ss_a_ack1", bus.a_ack_o, 1'b1);
    chk("ss_aux_addr", bus.m_addr_o, 32'h200);
    chk("ss_stall1", bus.c_stall_req_o, 1'b0);
    tick();

    // Core load blocked behind an outstanding aux load.
    do_reset();
    bus.a_load_i = 1'b1; bus.m_ready_i = 1'b1;
    settle();
    chk("ax_ack", bus.a_ack_o, 1'b1);
    chk("ax_addr", bus.m_addr_o, 32'h200);
    tick();
    bus.a_load_i = 1'b0; bus.c_load_i = 1'b1;
    settle();
    chk("ax_stall_w1", bus.c_stall_req_o, 1'b1);
    chk("ax_noissue_w1", bus.m_load_o, 1'b0);
    tick(); settle();
    chk("ax_stall_w2", bus.c_stall_req_o, 1'b1);
    tick();
    bus.m_load_valid_i = 1'b1; bus.m_load_data_i = 32'h5a5a_0001;
    settle();
    chk("ax_stall_ret", bus.c_stall_req_o, 1'b1);
    chk("ax_noissue_ret", bus.m_load_o, 1'b0);
    tick();
    bus.m_load_valid_i = 1'b0;
    settle();
    chk("ax_a_valid", bus.a_load_valid_o, 1'b1);
    chk("ax_a_data", bus.a_load_data_o, 32'h5a5a_0001);
    chk("ax_core_issue", bus.m_load_o, 1'b1);
    chk("ax_core_addr", bus.m_addr_o, 32'h100);
    chk("ax_core_stall", bus.c_stall_req_o, 1'b0);
    tick();
    bus.c_load_i = 1'b0;
    settle();
    chk("ax_pulse_end", bus.a_load_valid_o, 1'b0);
    tick();

    // Memory back-pressure on a core store.
    do_reset();
    bus.c_store_i = 1'b1; bus.c_addr_i = 32'h0000_0abc; bus.c_data_i = 32'hdead_beef;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("bp%0d_store", i), bus.m_store_o, 1'b1);
      chk($sformatf("bp%0d_addr", i), bus.m_addr_o, 32'h0000_0abc);
      chk($sformatf("bp%0d_data", i), bus.m_data_o, 32'hdead_beef);
      chk($sformatf("bp%0d_stall", i), bus.c_stall_req_o, 1'b1);
      tick();
    end
    bus.m_ready_i = 1'b1;
    settle();
    chk("bp_acc_store", bus.m_store_o, 1'b1);
    chk("bp_acc_stall", bus.c_stall_req_o, 1'b0);
    tick();

    // Reset while a core load is outstanding drops it.
    do_reset();
    bus.c_load_i = 1'b1; bus.m_ready_i = 1'b1;
    tick();
    clear();
    rst_i = 1'b1;
    bus.c_store_i = 1'b1; bus.a_store_i = 1'b1; bus.m_ready_i = 1'b1;
    settle();
    chk("rw_m_store", bus.m_store_o, 1'b0);
    chk("rw_a_ack", bus.a_ack_o, 1'b0);
    chk("rw_stall", bus.c_stall_req_o, 1'b0);
    tick();
    rst_i = 1'b0;
    clear();
    bus.m_load_valid_i = 1'b1; bus.m_load_data_i = 32'hbad0_bad0;
    tick();
    bus.m_load_valid_i = 1'b0;
    settle();
    chk("rw_no_valid", bus.c_load_valid_o, 1'b0);
    chk("rw_no_data", bus.c_load_data_o, 32'h0);
    bus.c_store_i = 1'b1; bus.m_ready_i = 1'b1;
    #0;
    chk("rw_issue", bus.m_store_o, 1'b1);
    chk("rw_issue_stall", bus.c_stall_req_o, 1'b0);
    tick();

    // Sustained contention: aux starves unless the fairness counter is built in.
    do_reset();
    bus.c_store_i = 1'b1; bus.a_store_i = 1'b1; bus.m_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic e;
`ifdef URV_DM_ARB_FAIR_EN
      e = (i == int'(Limit));
`else
      e = 1'b0;
`endif
      settle();
      chk($sformatf("cont%0d_a_ack", i), bus.a_ack_o, e);
      chk($sformatf("cont%0d_stall", i), bus.c_stall_req_o, e);
      tick();
    end

    // Randomized traffic against a transaction-level model.
    do_reset();
    c_busy = 0; a_busy = 0; outst = 0; exp_cv = 0; exp_av = 0;
    exp_cd = 32'h0; exp_ad = 32'h0; starve = 0;
    for (int n = 0; n < 400; n++) begin
      bit core_w, aux_w, e_ld, e_st, acc, e_stall, e_ack, nxt_cv, nxt_av;
      if (!c_busy && $urandom_range(1) == 1) begin
        int k;
        k = $urandom_range(1, 3);
        c_busy = 1; c_ld = k[0]; c_st = k[1]; c_ad = $urandom;
      end
      if (!a_busy && $urandom_range(2) == 0) begin
        int k;
        k = $urandom_range(1, 3);
        a_busy = 1; a_ld = k[0]; a_st = k[1]; a_ad = $urandom;
      end
      bus.c_load_i = c_busy & c_ld; bus.c_store_i = c_busy & c_st; bus.c_addr_i = c_ad;
      bus.a_load_i = a_busy & a_ld; bus.a_store_i = a_busy & a_st; bus.a_addr_i = a_ad;
      bus.m_ready_i = ($urandom_range(3) != 0);
      bus.m_load_valid_i = ($urandom_range(2) == 0);
      bus.m_load_data_i = $urandom;
      settle();

      core_w = 0; aux_w = 0; e_ld = 0; e_st = 0;
      if (outst == 0) begin
        aux_w  = a_busy && (!c_busy || (Fair && starve == int'(Limit)));
        core_w = c_busy && !aux_w;
        if (core_w) begin e_ld = c_ld; e_st = c_st && !c_ld; end
        if (aux_w)  begin e_ld = a_ld; e_st = a_st && !a_ld; end
      end
      acc     = (e_ld || e_st) && bus.m_ready_i;
      e_stall = c_busy && !(core_w && acc);
      e_ack   = aux_w && acc;

      chk("rnd_m_load", bus.m_load_o, e_ld);
      chk("rnd_m_store", bus.m_store_o, e_st);
      chk("rnd_c_stall", bus.c_stall_req_o, e_stall);
      chk("rnd_a_ack", bus.a_ack_o, e_ack);
      chk("rnd_c_valid", bus.c_load_valid_o, exp_cv);
      chk("rnd_a_valid", bus.a_load_valid_o, exp_av);
      chk("rnd_c_data", bus.c_load_data_o, exp_cd);
      chk("rnd_a_data", bus.a_load_data_o, exp_ad);
      if (e_ld || e_st) chk("rnd_m_addr", bus.m_addr_o, core_w ? c_ad : a_ad);

      nxt_cv = 0; nxt_av = 0;
      if (outst != 0) begin
        if (bus.m_load_valid_i) begin
          if (outst == 1) begin exp_cd = bus.m_load_data_i; nxt_cv = 1; end
          else            begin exp_ad = bus.m_load_data_i; nxt_av = 1; end
          outst = 0;
        end
      end else if (acc && e_ld) begin
        outst = core_w ? 1 : 2;
      end
      exp_cv = nxt_cv; exp_av = nxt_av;
      if (!a_busy || (aux_w && acc)) starve = 0;
      else if (core_w && acc) starve++;
      if (core_w && acc) c_busy = 0;
      if (aux_w && acc) a_busy = 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
